// File: rtl/puf_race_ctrl.sv
// ---------------------------------------------------------------------------
// puf_race_ctrl
//
// Sequencer for an arbiter PUF built from a chain of mux2x1 stages. A
// challenge word is latched onto the stage select lines. The race is then
// launched (optionally several times) and the arbiter decision is sampled
// through a 2-flop synchronizer. A single response bit is presented with a
// valid/ready handshake.
//
// Build option:
//   MAJORITY_VOTE_EN  defined   -> N_VOTES races per challenge, resp is the
//                                  strict majority of the sampled decisions
//                     undefined -> one race per challenge, resp is that
//                                  single sample
//
// Parameters:
//   N_STAGES       number of mux stages / challenge bits
//   SETTLE_CYCLES  length in clocks of each setup, launch and relax phase (>= 3)
//   N_VOTES        races per challenge when voting is compiled in
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   chal_in     challenge word
//   chal_valid  chal_in is valid
//   chal_ready  block can accept a challenge (IDLE only)
//   sel         stage select lines, bit i drives stage i
//   launch      race edge injected into both chain inputs
//   arb_in      asynchronous arbiter decision
//   resp        response bit
//   resp_valid  resp is valid (DONE)
//   resp_ready  consumer accepts resp
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module puf_race_ctrl #(
    parameter int N_STAGES      = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int N_VOTES       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_STAGES-1:0] chal_in,
    input  logic                chal_valid,
    output logic                chal_ready,
    output logic [N_STAGES-1:0] sel,
    output logic                launch,
    input  logic                arb_in,
    output logic                resp,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_RELAX  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef MAJORITY_VOTE_EN
    localparam int VOTES = N_VOTES;
`else
    localparam int VOTES = 1;
`endif

    localparam int CNT_W = $clog2(N_VOTES + 1);
    localparam int PH_W  = $clog2(SETTLE_CYCLES);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [PH_W-1:0]  phase_cnt;
    logic [CNT_W-1:0] vote_cnt;
    logic             arb_meta;
    logic             arb_sync;
    logic             phase_last;
    logic             timed_state;
    logic             take;
    logic             sample_now;
    logic             vote_result;

`ifdef MAJORITY_VOTE_EN
    logic [CNT_W-1:0] ones_cnt;
    assign vote_result = (ones_cnt > CNT_W'(VOTES / 2));
`else
    logic             vote_bit;
    assign vote_result = vote_bit;
`endif

    assign phase_last  = (phase_cnt == PH_W'(SETTLE_CYCLES - 1));
    assign timed_state = (state == ST_SETUP) || (state == ST_LAUNCH) || (state == ST_RELAX);
    assign take        = (state == ST_IDLE) && chal_valid && chal_ready;
    assign sample_now  = (state == ST_LAUNCH) && phase_last;

    // Decoded straight from the state register so that an asynchronous
    // reset removes the race edge and the valid flag without waiting for a clock.
    assign launch     = (state == ST_LAUNCH);
    assign resp_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

    // Each timed phase lasts SETTLE_CYCLES clocks; RELAX either re-launches
    // for another vote or finishes once every vote has been taken.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (take) state_next = ST_SETUP;
            ST_SETUP:  if (phase_last) state_next = ST_LAUNCH;
            ST_LAUNCH: if (phase_last) state_next = ST_RELAX;
            ST_RELAX:  if (phase_last) state_next = (vote_cnt < CNT_W'(VOTES)) ? ST_LAUNCH : ST_DONE;
            ST_DONE:   if (resp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // chal_ready is registered from the next state. It therefore stays low
    // while reset is held, rises on the first edge after release, and is
    // still low on the edge where DONE hands back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            sel        <= '0;
            chal_ready <= 1'b0;
            resp       <= 1'b0;
            vote_cnt   <= '0;
            arb_meta   <= 1'b0;
            arb_sync   <= 1'b0;
`ifdef MAJORITY_VOTE_EN
            ones_cnt   <= '0;
`else
            vote_bit   <= 1'b0;
`endif
        end else begin
            arb_meta   <= arb_in;
            arb_sync   <= arb_meta;
            state      <= state_next;
            chal_ready <= (state_next == ST_IDLE);

            if (timed_state && (state_next == state)) begin
                phase_cnt <= phase_cnt + PH_W'(1);
            end else begin
                phase_cnt <= '0;
            end

            if (take) begin
                sel      <= chal_in;
                vote_cnt <= '0;
                resp     <= 1'b0;
`ifdef MAJORITY_VOTE_EN
                ones_cnt <= '0;
`endif
            end

            // The arbiter has had the whole launch phase to settle, so the
            // decision is taken on the final launch cycle.
            if (sample_now) begin
                vote_cnt <= vote_cnt + CNT_W'(1);
`ifdef MAJORITY_VOTE_EN
                ones_cnt <= ones_cnt + CNT_W'(arb_sync);
`else
                vote_bit <= arb_sync;
`endif
            end

            if ((state == ST_RELAX) && (state_next == ST_DONE)) begin
                resp <= vote_result;
            end
        end
    end

endmodule

// File: doc/puf_race_ctrl.md
PUF_RACE_CTRL -- requirements
Module: puf_race_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 32: number of mux stages and challenge bits.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, minimum 3: cycles per setup, launch and relax phase.
REQ-003 SHALL have parameter N_VOTES, default 5: arbiter samples per challenge when voting is compiled in.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port chal_in, input, N_STAGES: challenge word.
REQ-007 SHALL have port chal_valid, input, 1: chal_in is valid.
REQ-008 SHALL have port chal_ready, output, 1: block can accept a challenge.
REQ-009 SHALL have port sel, output, N_STAGES: select lines to the mux2x1 chain; bit i drives stage i.
REQ-010 SHALL have port launch, output, 1: race edge injected into both chain inputs.
REQ-011 SHALL have port arb_in, input, 1: asynchronous arbiter decision.
REQ-012 SHALL have port resp, output, 1: PUF response bit.
REQ-013 SHALL have port resp_valid, output, 1: resp is valid.
REQ-014 SHALL have port resp_ready, input, 1: consumer accepts resp.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> SETUP -> LAUNCH -> RELAX -> (LAUNCH or DONE) -> IDLE.
REQ-017 SHALL drive chal_ready high only in IDLE; a transfer is chal_valid && chal_ready at a rising edge.
REQ-018 SHALL, on a transfer, register chal_in into sel, clear vote counters, and enter SETUP.
REQ-019 SHALL hold sel constant from the transfer until the next transfer.
REQ-020 SHALL stay SETTLE_CYCLES cycles in SETUP with launch=0, then enter LAUNCH.
REQ-021 SHALL drive launch=1 for exactly SETTLE_CYCLES cycles in LAUNCH.
REQ-022 SHALL pass arb_in through a 2-flop synchronizer.
REQ-023 SHALL sample the synchronized arb_in on the last LAUNCH cycle, increment ones_cnt if 1, and increment vote_cnt.
REQ-024 SHALL stay SETTLE_CYCLES cycles in RELAX with launch=0.
REQ-025 SHALL leave RELAX for LAUNCH while vote_cnt < N_VOTES, otherwise for DONE.
REQ-026 SHALL size ones_cnt and vote_cnt as clog2(N_VOTES+1) bits.
REQ-027 SHALL set resp = (ones_cnt > N_VOTES/2) using integer division; for even N_VOTES a tie yields 0.
REQ-028 SHALL hold resp_valid=1 and resp stable in DONE until resp_ready=1, then return to IDLE on that edge.
REQ-029 SHALL assert resp_valid exactly SETTLE_CYCLES*(1+2*N_VOTES) cycles after the transfer edge; this is 44 cycles at defaults.
REQ-030 SHALL ignore chal_valid while busy, and SHALL NOT accept a new challenge in the cycle DONE exits.

Reset
REQ-031 SHALL, on rst asserting, immediately and without a clock force state=IDLE, sel=0, launch=0, resp=0, resp_valid=0, busy=0, chal_ready=0, counters=0, and synchronizer flops=0.
REQ-032 SHALL raise chal_ready on the first rising clk edge after rst deasserts.
REQ-033 SHALL, when rst asserts mid-race, drop launch within the same cycle and discard partial votes; no resp_valid follows.

Configuration
REQ-034 SHALL use macro MAJORITY_VOTE_EN to select voting.
REQ-035 SHALL, with MAJORITY_VOTE_EN defined, behave as in REQ-023 to REQ-029.
REQ-036 SHALL, without MAJORITY_VOTE_EN, treat N_VOTES as 1, set resp to the single synchronized sample, and omit ones_cnt; resp_valid then asserts 3*SETTLE_CYCLES cycles after the transfer (12 at defaults).

Verification
REQ-037 SHALL cover: defaults, chal_in=32'hA5A5_0F0F, arb_in held 1 -> sel=32'hA5A5_0F0F one cycle after transfer; 5 launch pulses each 4 cycles; resp_valid at cycle 44 with resp=1.
REQ-038 SHALL cover: arb_in per vote 1,0,1,0,0 (held per LAUNCH phase) -> resp=0; arb_in 1,1,0,0,1 -> resp=1.
REQ-039 SHALL cover: resp_ready held low 10 cycles after resp_valid -> resp_valid and resp stable; chal_valid during this time is not accepted; IDLE follows the resp_ready edge.
REQ-040 SHALL cover: rst pulsed mid-third-LAUNCH -> launch=0 and sel=0 without a clock edge; chal_ready=1 on the first edge after release; no resp_valid.
REQ-041 SHALL cover: build without MAJORITY_VOTE_EN, arb_in=1 -> exactly one launch pulse; resp=1 with resp_valid at cycle 12.
REQ-042 SHALL cover: back-to-back challenges with chal_valid held high and resp_ready tied high -> second transfer no earlier than one cycle after DONE exit.
